move_input_ctrl: RTL and testbench
==================================

# move_input_ctrl

Parametrised front end for the board's movement push-buttons, the successor to feeding the raw `MOVE` bus straight into the VGA/game logic. Each of `CHANNELS` inputs is synchronised, debounced and turned into discrete move events. With auto-repeat compiled in, a held button also produces delayed-auto-shift (DAS) repeats. Events are arbitrated into a small first-word-fall-through (FWFT) FIFO and consumed by the game controller through a valid/ready handshake.

## Interface
- `CHANNELS`, 4: number of button inputs, range 1..16.
- `ACTIVE_LOW`, 1: 1 means a button reads 0 when pressed (DE2 keys); 0 means it reads 1 when pressed.
- `DEBOUNCE_CYCLES`, 500000: consecutive cycles a new level must persist before it is accepted. Minimum 1.
- `DAS_CYCLES`, 8000000: hold time from the press event to the first repeat. Minimum 1.
- `ARR_CYCLES`, 2500000: period between successive repeats. Minimum 1.
- `FIFO_DEPTH`, 4: event FIFO entries; power of two, at least 2.
- `clock  in  1`: single clock; every flop is on its rising edge.
- `reset  in  1`: synchronous, active-high reset.
- `move_in  in  CHANNELS`: raw asynchronous button levels.
- `evt_valid  out  1`: FIFO head is a valid event.
- `evt_ready  in  1`: consumer accepts the head event.
- `evt_chan  out  max(1,$clog2(CHANNELS))`: channel index of the head event.
- `evt_repeat  out  1`: 0 for an initial press event, 1 for an auto-repeat event.
- `held  out  CHANNELS`: debounced pressed state, 1 = pressed.
- `overflow  out  1`: sticky flag, set when an event is dropped; cleared only by reset.

## Operation
- Conditioning: each input passes through a two-flop synchroniser, then is polarity-normalised according to `ACTIVE_LOW`.
- Debounce, per channel:
  - A counter increments on every edge where the synchronised level differs from `held[i]`; it clears when the two are equal.
  - On the edge where the counter would reach `DEBOUNCE_CYCLES`, `held[i]` toggles and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- Press event: a 0->1 transition of `held[i]` generates an event with repeat=0. Releases generate no event.
- Auto-repeat FSM, per channel (only with `MOVE_AUTOREPEAT_EN`):
  - States are IDLE, DELAY and REPEAT.
  - IDLE -> DELAY on press; the counter clears.
  - DELAY -> REPEAT when the counter reaches `DAS_CYCLES-1`; this emits a repeat=1 event and clears the counter.
  - In REPEAT, a repeat=1 event is emitted every `ARR_CYCLES` cycles.
  - From any state, `held[i]`=0 forces IDLE. That edge emits no event.
- Pending stage:
  - Each channel has one pending bit plus a repeat bit.
  - A new event on a channel whose pending bit is already set is dropped and sets `overflow`. The older pending event is kept.
- Arbiter: each cycle, the lowest-indexed pending channel is written to the FIFO if the FIFO is not full, and its pending bit clears on that edge. A channel may set a new pending event on the same edge its previous one is written.
- FIFO:
  - FWFT: `evt_chan` and `evt_repeat` are valid whenever `evt_valid`=1 and hold steady until popped.
  - A pop happens on an edge with `evt_valid & evt_ready`.
  - A write is blocked while the FIFO is full, even if a pop happens in the same cycle.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Simultaneous push and pop when neither full nor empty leaves the count unchanged.
- Events already pending or in the FIFO are delivered even if the button has since been released.

## Timing
- Reset values:
  - `evt_valid`=0, `evt_chan`=0, `evt_repeat`=0, `held`=0, `overflow`=0.
  - FIFO empty, all pending bits 0, all FSMs in IDLE, all counters 0.
  - Synchroniser flops load the released level.
- A reset asserted mid-operation discards all pending and queued events on that edge.
- Press latency:
  - The input changes before edge 0; the synchronised value is valid after edge 2.
  - `held` and the pending bit set on edge 2+`DEBOUNCE_CYCLES`.
  - The FIFO write happens on edge 3+`DEBOUNCE_CYCLES`, and `evt_valid` is high in the cycle that follows.
- Repeat timing: the first repeat sets pending `DAS_CYCLES` edges after the press pending-set. Later repeats follow every `ARR_CYCLES` edges.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles, measured after the synchroniser, produce no change.
- Throughput: at most one FIFO write and one FIFO pop per cycle.

## Configuration
- `MOVE_AUTOREPEAT_EN` defined: the DAS/ARR FSMs and counters are built; `DAS_CYCLES` and `ARR_CYCLES` are active.
- `MOVE_AUTOREPEAT_EN` undefined: no repeat logic is instantiated. Only press events occur, `evt_repeat` is a constant 0, and `DAS_CYCLES`/`ARR_CYCLES` are ignored.

## Test plan
All scenarios use CHANNELS=4, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, DAS_CYCLES=10, ARR_CYCLES=3, FIFO_DEPTH=4, `evt_ready`=1 unless stated.
- Reset: assert reset for 2 cycles with all inputs 1 -> every output is 0 and stays 0 for 20 cycles.
- Press latency: drive `move_in[2]` to 0 before edge 0 -> `held[2]` rises after edge 6; `evt_valid`=1 with `evt_chan`=2 and `evt_repeat`=0 in the cycle after edge 7, for exactly one cycle.
- Bounce rejection: pulse `move_in[1]` low for 3 cycles, repeated 5 times with 3-cycle gaps -> no event, and `held[1]` stays 0.
- Auto-repeat (macro defined): hold `move_in[0]` low for 30 cycles -> one repeat=0 event, then repeat=1 events 10 cycles after the press and every 3 cycles after that. Release -> no further events and no release event.
- Simultaneous press: channels 3 and 1 press on the same edge -> events come out in the order chan 1 then chan 3, on consecutive cycles.
- Backpressure and overflow: `evt_ready`=0 while channels 0 and 1 are repeatedly pressed and released (macro undefined) -> the FIFO fills to 4, `evt_valid` and the head entry stay stable, and `overflow` rises on the first dropped event. Raising `evt_ready` then drains 4 entries in FIFO order, followed by the retained pending events.

Source files
------------

// File: rtl/move_input_ctrl.sv
// move_input_ctrl: push-button front end for the movement keys.
//
// Each raw button level is synchronised, polarity-normalised and debounced. A debounced press
// becomes a move event. When MOVE_AUTOREPEAT_EN is defined, a held button also produces
// delayed-auto-shift repeats. Events wait in a one-deep pending slot per channel. A
// lowest-index-first arbiter moves them into a first-word-fall-through FIFO, which the game
// controller reads with a valid/ready handshake.
//
// Ports:
//   clock       rising-edge clock for every flop
//   reset       synchronous, active-high reset
//   move_in     raw asynchronous button levels, CHANNELS wide
//   evt_valid   FIFO head holds an event
//   evt_ready   consumer accepts the head event
//   evt_chan    channel index of the head event
//   evt_repeat  0 = initial press, 1 = auto-repeat (constant 0 without MOVE_AUTOREPEAT_EN)
//   held        debounced pressed state, 1 = pressed
//   overflow    sticky; set when an event is dropped, cleared only by reset
//
// Build option: define MOVE_AUTOREPEAT_EN to build the DAS/ARR repeat logic.

module move_input_ctrl #(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DAS_CYCLES      = 8000000,
    parameter int unsigned ARR_CYCLES      = 2500000,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                                               clock,
    input  logic                                               reset,
    input  logic [CHANNELS-1:0]                                move_in,
    output logic                                               evt_valid,
    input  logic                                               evt_ready,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] evt_chan,
    output logic                                               evt_repeat,
    output logic [CHANNELS-1:0]                                held,
    output logic                                               overflow
);

    localparam int unsigned ChanW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    localparam logic [AddrW:0] FullCount = (AddrW + 1)'(FIFO_DEPTH);
    localparam logic [CHANNELS-1:0] ReleasedRaw = (ACTIVE_LOW != 0) ? '1 : '0;

    // Elaboration-time parameter sanity checks.
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_chk_channels
        $error("CHANNELS must be in 1..16");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (DAS_CYCLES < 1 || ARR_CYCLES < 1) begin : g_chk_repeat
        $error("DAS_CYCLES and ARR_CYCLES must be at least 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end

    // ------------------------------------------------------------------------------------
    // Conditioning: two-flop synchroniser, then a registered polarity-normalise stage.
    // ------------------------------------------------------------------------------------
    logic [CHANNELS-1:0] sync1_q, sync2_q, level_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= ReleasedRaw;
            sync2_q <= ReleasedRaw;
            level_q <= '0;
        end else begin
            sync1_q <= move_in;
            sync2_q <= sync1_q;
            level_q <= (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
        end
    end

    // ------------------------------------------------------------------------------------
    // Debounce: held toggles once the level has disagreed for DEBOUNCE_CYCLES edges.
    // ------------------------------------------------------------------------------------
    logic [DbW-1:0]      db_cnt_q [CHANNELS];
    logic [DbW-1:0]      db_cnt_d [CHANNELS];
    logic [CHANNELS-1:0] held_q, held_d, press;

    always_comb begin
        held_d = held_q;
        for (int i = 0; i < CHANNELS; i++) begin
            db_cnt_d[i] = '0;
            if (level_q[i] != held_q[i]) begin
                if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
                    held_d[i] = level_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
        press = held_d & ~held_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            held_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            held_q   <= held_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign held = held_q;

    // ------------------------------------------------------------------------------------
    // Event sources
    // ------------------------------------------------------------------------------------
    logic [CHANNELS-1:0] new_evt;

`ifdef MOVE_AUTOREPEAT_EN
    localparam int unsigned RptMax = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
    localparam int unsigned RptW   = (RptMax > 1) ? $clog2(RptMax) : 1;

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rpt_state_e;

    rpt_state_e          rpt_state_q [CHANNELS];
    rpt_state_e          rpt_state_d [CHANNELS];
    logic [RptW-1:0]     rpt_cnt_q [CHANNELS];
    logic [RptW-1:0]     rpt_cnt_d [CHANNELS];
    logic [CHANNELS-1:0] rpt_evt;

    always_comb begin
        rpt_evt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rpt_state_d[i] = rpt_state_q[i];
            rpt_cnt_d[i]   = rpt_cnt_q[i];
            case (rpt_state_q[i])
                StIdle: begin
                    if (press[i]) begin
                        rpt_state_d[i] = StDelay;
                        rpt_cnt_d[i]   = '0;
                    end
                end
                StDelay: begin
                    if (rpt_cnt_q[i] == RptW'(DAS_CYCLES - 1)) begin
                        rpt_state_d[i] = StRepeat;
                        rpt_cnt_d[i]   = '0;
                        rpt_evt[i]     = 1'b1;
                    end else begin
                        rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                    end
                end
                StRepeat: begin
                    if (rpt_cnt_q[i] == RptW'(ARR_CYCLES - 1)) begin
                        rpt_cnt_d[i] = '0;
                        rpt_evt[i]   = 1'b1;
                    end else begin
                        rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                    end
                end
                default: rpt_state_d[i] = StIdle;
            endcase
            // Release wins over everything, including a repeat due on the same edge.
            if (!held_d[i]) begin
                rpt_state_d[i] = StIdle;
                rpt_cnt_d[i]   = '0;
                rpt_evt[i]     = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                rpt_state_q[i] <= StIdle;
                rpt_cnt_q[i]   <= '0;
            end
        end else begin
            rpt_state_q <= rpt_state_d;
            rpt_cnt_q   <= rpt_cnt_d;
        end
    end

    // A press only fires from StIdle and a repeat never does, so the two are exclusive.
    assign new_evt = press | rpt_evt;
`else
    assign new_evt = press;
`endif

    // ------------------------------------------------------------------------------------
    // Pending slots and lowest-index arbiter
    // ------------------------------------------------------------------------------------
    logic [CHANNELS-1:0] pend_q, pend_d, grant;
    logic                overflow_q, overflow_d;
    logic                push, pop, fifo_full;
    logic [ChanW-1:0]    push_chan;
`ifdef MOVE_AUTOREPEAT_EN
    logic [CHANNELS-1:0] prep_q, prep_d;
    logic                push_rep;
`endif

    always_comb begin
        grant     = '0;
        push      = 1'b0;
        push_chan = '0;
`ifdef MOVE_AUTOREPEAT_EN
        push_rep  = 1'b0;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            if (pend_q[i] && !push && !fifo_full) begin
                grant[i]  = 1'b1;
                push      = 1'b1;
                push_chan = ChanW'(i);
`ifdef MOVE_AUTOREPEAT_EN
                push_rep  = prep_q[i];
`endif
            end
        end
    end

    always_comb begin
        // Clearing granted slots first lets a slot refill on the edge it is drained.
        pend_d     = pend_q & ~grant;
        overflow_d = overflow_q;
`ifdef MOVE_AUTOREPEAT_EN
        prep_d     = prep_q;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            if (new_evt[i]) begin
                if (pend_d[i]) begin
                    overflow_d = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
`ifdef MOVE_AUTOREPEAT_EN
                    prep_d[i] = rpt_evt[i];
`endif
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q     <= '0;
            overflow_q <= 1'b0;
`ifdef MOVE_AUTOREPEAT_EN
            prep_q     <= '0;
`endif
        end else begin
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
`ifdef MOVE_AUTOREPEAT_EN
            prep_q     <= prep_d;
`endif
        end
    end

    assign overflow = overflow_q;

    // ------------------------------------------------------------------------------------
    // FWFT event FIFO
    // ------------------------------------------------------------------------------------
    logic [ChanW-1:0] mem_chan [FIFO_DEPTH];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AddrW:0]   count_q;
`ifdef MOVE_AUTOREPEAT_EN
    logic             mem_rep [FIFO_DEPTH];
`endif

    assign fifo_full = (count_q == FullCount);
    assign evt_valid = (count_q != '0);
    assign pop       = evt_valid & evt_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_chan[wr_ptr_q] <= push_chan;
`ifdef MOVE_AUTOREPEAT_EN
            mem_rep[wr_ptr_q]  <= push_rep;
`endif
        end
    end

    // Head fields read as 0 while empty so the outputs are defined out of reset.
    assign evt_chan = evt_valid ? mem_chan[rd_ptr_q] : '0;
`ifdef MOVE_AUTOREPEAT_EN
    assign evt_repeat = evt_valid ? mem_rep[rd_ptr_q] : 1'b0;
`else
    assign evt_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_move_input_ctrl.sv
module tb_move_input_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] move_in = 4'b1111;
    logic       evt_ready = 1'b1;
    logic       evt_valid;
    logic [1:0] evt_chan;
    logic       evt_repeat;
    logic [3:0] held;
    logic       overflow;

    move_input_ctrl #(
        .CHANNELS        (4),
        .ACTIVE_LOW      (1),
        .DEBOUNCE_CYCLES (4),
        .DAS_CYCLES      (10),
        .ARR_CYCLES      (3),
        .FIFO_DEPTH      (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .move_in    (move_in),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_chan   (evt_chan),
        .evt_repeat (evt_repeat),
        .held       (held),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int chan;
        int rep;
        int cyc;   // negedge cycle stamp the event must appear at, -1 = any
    } exp_t;

    typedef struct {
        logic [3:0] press;     // channels pulled low together
        int         hold;      // cycles the raw inputs stay low
        logic [3:0] exp_held;  // held after edge 6, and the channels that must produce events
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[6];

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic expect_evt(input int chan, input int rep, input int at);
        exp_t e;
        e.chan = chan;
        e.rep  = rep;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    // Scoreboard side: every accepted event must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && evt_valid && evt_ready) begin
            check("evt_expected", longint'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("evt_chan", longint'(evt_chan), mon_e.chan);
                check("evt_repeat", longint'(evt_repeat), mon_e.rep);
                if (mon_e.cyc >= 0) check("evt_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  base;
        int  n;
        logic seen;

        vecs[0] = '{press: 4'b0010, hold: 3, exp_held: 4'b0000};  // one cycle short
        vecs[1] = '{press: 4'b0001, hold: 4, exp_held: 4'b0001};  // shortest accepted
        vecs[2] = '{press: 4'b1010, hold: 5, exp_held: 4'b1010};  // simultaneous 1 and 3
        vecs[3] = '{press: 4'b1111, hold: 4, exp_held: 4'b1111};  // all channels
        vecs[4] = '{press: 4'b1000, hold: 2, exp_held: 4'b0000};
        vecs[5] = '{press: 4'b0101, hold: 7, exp_held: 4'b0101};

        // Reset: everything quiet during and after
        reset = 1'b1;
        move_in = 4'b1111;
        evt_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            check("reset_quiet", longint'({evt_valid, evt_chan, evt_repeat, held, overflow}), 0);
        end

        // Press latency on channel 2
        base = cyc;
        move_in[2] = 1'b0;
        for (int k = 0; k < 6; k++) step();
        check("lat_held_e5", longint'(held[2]), 0);
        expect_evt(2, 0, base + 8);
        step();
        check("lat_held_e6", longint'(held[2]), 1);
        check("lat_valid_e6", longint'(evt_valid), 0);
        step();
        check("lat_valid_e7", longint'(evt_valid), 1);
        step();
        check("lat_valid_e8", longint'(evt_valid), 0);
        move_in = 4'b1111;
        for (int k = 0; k < 20; k++) step();
        check("lat_drained", sb.size(), 0);

        // Bounce rejection on channel 1
        seen = 1'b0;
        for (int r = 0; r < 5; r++) begin
            move_in[1] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                step();
                seen |= held[1];
            end
            move_in[1] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                step();
                seen |= held[1];
            end
        end
        for (int k = 0; k < 15; k++) step();
        check("bounce_held", longint'(seen), 0);

        // Table-driven press vectors
        for (int v = 0; v < 6; v++) begin
            base = cyc;
            n = 0;
            for (int c = 0; c < 4; c++) begin
                if (vecs[v].exp_held[c]) begin
                    expect_evt(c, 0, base + 8 + n);
                    n++;
                end
            end
            move_in = ~vecs[v].press;
            for (int k = 0; k < 7; k++) begin
                step();
                if (k == vecs[v].hold - 1) move_in = 4'b1111;
            end
            check("vec_held", longint'(held), longint'(vecs[v].exp_held));
            for (int k = 0; k < 25; k++) step();
            check("vec_drained", sb.size(), 0);
        end

`ifdef MOVE_AUTOREPEAT_EN
        // Auto-repeat: press at edge 6, repeats pend at 16, 19, ... until held falls at 36
        base = cyc;
        expect_evt(0, 0, base + 8);
        for (int m = 0; m < 7; m++) expect_evt(0, 1, base + 18 + 3 * m);
        move_in[0] = 1'b0;
        for (int k = 0; k < 30; k++) step();
        move_in = 4'b1111;
        for (int k = 0; k < 30; k++) step();
        check("rpt_drained", sb.size(), 0);
`endif

        // Backpressure: two rounds fill the FIFO, third waits pending, fourth is dropped
        evt_ready = 1'b0;
        seen = 1'b0;
        for (int r = 0; r < 4; r++) begin
            if (r < 3) begin
                expect_evt(0, 0, -1);
                expect_evt(1, 0, -1);
            end
            move_in = 4'b1100;
            for (int k = 0; k < 12; k++) begin
                step();
                if (k == 3) move_in = 4'b1111;
                if (r == 3 && k == 5) check("bp_ovf_before", longint'(overflow), 0);
                if (r == 3 && k == 6) check("bp_ovf_after", longint'(overflow), 1);
                if ((r > 0 || k >= 7) && (!evt_valid || evt_chan != 2'd0 || evt_repeat))
                    seen = 1'b1;
            end
            if (r < 3) check("bp_no_overflow", longint'(overflow), 0);
        end
        check("bp_head_stable", longint'(seen), 0);
        evt_ready = 1'b1;
        for (int k = 0; k < 20; k++) step();
        check("bp_drained", sb.size(), 0);
        check("bp_ovf_sticky", longint'(overflow), 1);

        // Reset mid-operation discards the queued event and clears overflow
        evt_ready = 1'b0;
        move_in[3] = 1'b0;
        for (int k = 0; k < 4; k++) step();
        move_in = 4'b1111;
        for (int k = 0; k < 5; k++) step();
        check("mid_valid", longint'(evt_valid), 1);
        check("mid_chan", longint'(evt_chan), 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_valid", longint'(evt_valid), 0);
        check("mid_rst_ovf", longint'(overflow), 0);
        check("mid_rst_held", longint'(held), 0);
        evt_ready = 1'b1;
        for (int k = 0; k < 20; k++) step();
        check("final_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
